// File: rtl/hls_deadlock_monitor_param_pkg.sv
// Shared definitions for the parametrised HLS deadlock monitor: FSM state
// encoding, block-source codes and fixed internal widths.
package hls_deadlock_monitor_param_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMING  = 2'd1,
    BLOCKED = 2'd2
  } state_e;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_CUR   = 2'd1;
  localparam logic [1:0] SRC_SEQ   = 2'd2;
  localparam logic [1:0] SRC_CHILD = 2'd3;

  localparam int PERSIST_W = 8;
  localparam int IDX_W     = 5;

endpackage

// File: rtl/hls_deadlock_monitor_param_prio_enc.sv
// Lowest-index priority encoder with a valid flag; the index is zero-extended
// to IDX_W bits.
module hls_deadlock_prio_enc #(
  parameter int N     = 7,
  parameter int IDX_W = 5
) (
  input  logic [N-1:0]     vec_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    // Scan downwards so the last hit written is the lowest set index.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/hls_deadlock_monitor_param.sv
// Deadlock monitor for one HLS sub-instance: raises block once a blocking
// condition has persisted THRESH cycles and records the first source.
module hls_deadlock_monitor_param
  import hls_deadlock_monitor_param_pkg::*;
#(
  parameter int                N_AXIS      = 7,
  parameter int                N_SUB       = 1,
  parameter logic [N_AXIS-1:0] CUR_MASK    = 7'b0000010,
  parameter logic [N_AXIS-1:0] SINGLE_MASK = 7'b0111100,
  parameter logic [N_AXIS-1:0] PAR_MASK    = 7'b0000000,
  parameter int                THRESH      = 4,
  parameter bit                STICKY      = 1'b0,
  parameter int                CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_AXIS-1:0] inst_idle_sigs,
  input  logic [N_SUB-1:0]  inst_block_sigs,
  input  logic              clear,
  output logic              block,
  output logic [1:0]        block_src,
  output logic [4:0]        block_idx,
  output logic [CNT_W-1:0]  block_cycles
);

  localparam logic [PERSIST_W-1:0] THRESH_M1 = PERSIST_W'(THRESH - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [N_AXIS-1:0] eff, cur_vec, seq_vec;
  logic              par_hit, cur_v, seq_v, child_v, cond;
  logic [IDX_W-1:0]  cur_idx, seq_idx, child_idx;
  logic [1:0]        src_cap;
  logic [IDX_W-1:0]  idx_cap;

  assign eff     = axis_block_sigs & ~inst_idle_sigs;
  assign cur_vec = eff & CUR_MASK;
  assign par_hit = (PAR_MASK != '0) && (&(eff | ~PAR_MASK));
  // A parallel hit contributes its whole mask, so its lowest mask bit is reported.
  assign seq_vec = (eff & SINGLE_MASK) | (par_hit ? PAR_MASK : '0);

  hls_deadlock_prio_enc #(.N(N_AXIS), .IDX_W(IDX_W)) u_enc_cur (
    .vec_i(cur_vec), .valid_o(cur_v), .idx_o(cur_idx)
  );
  hls_deadlock_prio_enc #(.N(N_AXIS), .IDX_W(IDX_W)) u_enc_seq (
    .vec_i(seq_vec), .valid_o(seq_v), .idx_o(seq_idx)
  );
  hls_deadlock_prio_enc #(.N(N_SUB), .IDX_W(IDX_W)) u_enc_child (
    .vec_i(inst_block_sigs), .valid_o(child_v), .idx_o(child_idx)
  );

  assign cond = cur_v | seq_v | child_v;

  always_comb begin
    src_cap = SRC_NONE;
    idx_cap = '0;
    if (cur_v) begin
      src_cap = SRC_CUR;
      idx_cap = cur_idx;
    end else if (seq_v) begin
      src_cap = SRC_SEQ;
      idx_cap = seq_idx;
    end else if (child_v) begin
      src_cap = SRC_CHILD;
      idx_cap = child_idx;
    end
  end

  state_e               state_q, state_d;
  logic [PERSIST_W-1:0] persist_q, persist_d;
  logic [CNT_W-1:0]     cycles_q, cycles_d;
  logic                 block_q, block_d;
  logic [1:0]           src_q, src_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  always_comb begin
    state_d   = state_q;
    persist_d = persist_q;
    cycles_d  = cycles_q;
    block_d   = block_q;
    src_d     = src_q;
    idx_d     = idx_q;
    if (clear) begin
      state_d   = IDLE;
      persist_d = '0;
      cycles_d  = '0;
      block_d   = 1'b0;
      src_d     = SRC_NONE;
      idx_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cond) begin
            persist_d = PERSIST_W'(1);
            cycles_d  = CNT_W'(1);
            if (THRESH == 1) begin
              state_d = BLOCKED;
              block_d = 1'b1;
              src_d   = src_cap;
              idx_d   = idx_cap;
            end else begin
              state_d = ARMING;
            end
          end
        end
        ARMING: begin
          if (!cond) begin
            state_d   = IDLE;
            persist_d = '0;
            cycles_d  = '0;
          end else begin
            persist_d = persist_q + 1'b1;
            cycles_d  = sat_inc(cycles_q);
            if (persist_q == THRESH_M1) begin
              state_d = BLOCKED;
              block_d = 1'b1;
              src_d   = src_cap;
              idx_d   = idx_cap;
            end
          end
        end
        BLOCKED: begin
          if (cond) begin
            cycles_d = sat_inc(cycles_q);
          end else if (!STICKY) begin
            state_d   = IDLE;
            persist_d = '0;
            cycles_d  = '0;
            block_d   = 1'b0;
            src_d     = SRC_NONE;
            idx_d     = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      persist_q <= '0;
      cycles_q  <= '0;
      block_q   <= 1'b0;
      src_q     <= SRC_NONE;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      persist_q <= persist_d;
      cycles_q  <= cycles_d;
      block_q   <= block_d;
      src_q     <= src_d;
      idx_q     <= idx_d;
    end
  end

  assign block        = block_q;
  assign block_src    = src_q;
  assign block_idx    = idx_q;
  assign block_cycles = cycles_q;

endmodule

// File: tb/tb_hls_deadlock_monitor_param.sv
// Directed bench for hls_deadlock_monitor_param: a per-cycle vector table on
// the default configuration plus sequences on parametrised variants.
module tb_hls_deadlock_monitor_param;

  logic       clock;
  logic       reset_n;
  logic [6:0] axis_block_sigs;
  logic [6:0] inst_idle_sigs;
  logic [0:0] inst_block_sigs;
  logic       clear;

  logic        d_blk, p_blk, s_blk, c_blk, t_blk;
  logic [1:0]  d_src, p_src, s_src, c_src, t_src;
  logic [4:0]  d_idx, p_idx, s_idx, c_idx, t_idx;
  logic [15:0] d_cyc, p_cyc, s_cyc, t_cyc;
  logic [3:0]  c_cyc;

  int n_cmp = 0;
  int n_bad = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  hls_deadlock_monitor_param u_def (
    .clock(clock), .reset_n(reset_n), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .clear(clear),
    .block(d_blk), .block_src(d_src), .block_idx(d_idx), .block_cycles(d_cyc)
  );

  hls_deadlock_monitor_param #(.PAR_MASK(7'b1000001)) u_par (
    .clock(clock), .reset_n(reset_n), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .clear(clear),
    .block(p_blk), .block_src(p_src), .block_idx(p_idx), .block_cycles(p_cyc)
  );

  hls_deadlock_monitor_param #(.STICKY(1'b1)) u_sticky (
    .clock(clock), .reset_n(reset_n), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .clear(clear),
    .block(s_blk), .block_src(s_src), .block_idx(s_idx), .block_cycles(s_cyc)
  );

  hls_deadlock_monitor_param #(.CNT_W(4)) u_sat (
    .clock(clock), .reset_n(reset_n), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .clear(clear),
    .block(c_blk), .block_src(c_src), .block_idx(c_idx), .block_cycles(c_cyc)
  );

  hls_deadlock_monitor_param #(.THRESH(1)) u_t1 (
    .clock(clock), .reset_n(reset_n), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs), .clear(clear),
    .block(t_blk), .block_src(t_src), .block_idx(t_idx), .block_cycles(t_cyc)
  );

  typedef struct {
    logic [6:0]  axis;
    logic [6:0]  idle;
    logic        inst;
    logic        clr;
    logic        blk;
    logic [1:0]  src;
    logic [4:0]  idx;
    logic [15:0] cyc;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input logic [6:0] axis, input logic [6:0] idle, input logic inst,
                      input logic clr, input logic blk, input logic [1:0] src,
                      input logic [4:0] idx, input logic [15:0] cyc);
    vec_t v;
    v.axis = axis; v.idle = idle; v.inst = inst; v.clr = clr;
    v.blk = blk; v.src = src; v.idx = idx; v.cyc = cyc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] axis, input logic [6:0] idle, input logic inst,
                       input logic clr);
    axis_block_sigs = axis;
    inst_idle_sigs  = idle;
    inst_block_sigs = inst;
    clear           = clr;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    drive(7'b0, 7'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(7'b0, 7'b0, 1'b0, 1'b0);
    #12;
    chk("rst.blk", 32'(d_blk), 32'd0);
    chk("rst.src", 32'(d_src), 32'd0);
    chk("rst.idx", 32'(d_idx), 32'd0);
    chk("rst.cyc", 32'(d_cyc), 32'd0);
    reset_n = 1'b1;

    //   axis        idle        inst clr  blk src idx cyc
    addv(7'b0000000, 7'b0000000, 0, 0,  0, 0, 0, 0);
    addv(7'b0000010, 7'b0000000, 0, 0,  0, 0, 0, 1);
    addv(7'b0000010, 7'b0000000, 0, 0,  0, 0, 0, 2);
    addv(7'b0000010, 7'b0000000, 0, 0,  0, 0, 0, 3);
    addv(7'b0000010, 7'b0000000, 0, 0,  1, 1, 1, 4);
    addv(7'b0000010, 7'b0000000, 0, 0,  1, 1, 1, 5);
    addv(7'b0000010, 7'b0000000, 0, 0,  1, 1, 1, 6);
    addv(7'b0000000, 7'b0000000, 0, 0,  0, 0, 0, 0);
    addv(7'b0001000, 7'b0000000, 0, 0,  0, 0, 0, 1);
    addv(7'b0001000, 7'b0000000, 0, 0,  0, 0, 0, 2);
    addv(7'b0001000, 7'b0000000, 0, 0,  0, 0, 0, 3);
    addv(7'b0000000, 7'b0000000, 0, 0,  0, 0, 0, 0);
    addv(7'b0100010, 7'b0000010, 0, 0,  0, 0, 0, 1);
    addv(7'b0100010, 7'b0000010, 0, 0,  0, 0, 0, 2);
    addv(7'b0100010, 7'b0000010, 0, 0,  0, 0, 0, 3);
    addv(7'b0100010, 7'b0000010, 0, 0,  1, 2, 5, 4);
    addv(7'b0000000, 7'b0000000, 0, 0,  0, 0, 0, 0);
    addv(7'b0000000, 7'b0000000, 1, 0,  0, 0, 0, 1);
    addv(7'b0000000, 7'b0000000, 1, 0,  0, 0, 0, 2);
    addv(7'b0000000, 7'b0000000, 1, 0,  0, 0, 0, 3);
    addv(7'b0000000, 7'b0000000, 1, 0,  1, 3, 0, 4);
    addv(7'b0000000, 7'b0000000, 0, 0,  0, 0, 0, 0);
    addv(7'b0100110, 7'b0000000, 1, 0,  0, 0, 0, 1);
    addv(7'b0100110, 7'b0000000, 1, 0,  0, 0, 0, 2);
    addv(7'b0100110, 7'b0000000, 1, 0,  0, 0, 0, 3);
    addv(7'b0100110, 7'b0000000, 1, 0,  1, 1, 1, 4);
    addv(7'b0100110, 7'b0000000, 1, 1,  0, 0, 0, 0);
    addv(7'b0100110, 7'b0000000, 1, 0,  0, 0, 0, 1);
    addv(7'b0000000, 7'b0000000, 0, 0,  0, 0, 0, 0);
    addv(7'b1111111, 7'b1111111, 0, 0,  0, 0, 0, 0);
    addv(7'b1000001, 7'b0000000, 0, 0,  0, 0, 0, 0);
    addv(7'b0101100, 7'b0000000, 0, 0,  0, 0, 0, 1);
    addv(7'b0101100, 7'b0000000, 0, 0,  0, 0, 0, 2);
    addv(7'b0101100, 7'b0000000, 0, 0,  0, 0, 0, 3);
    addv(7'b0101100, 7'b0000000, 0, 0,  1, 2, 2, 4);
    addv(7'b0000000, 7'b0000000, 0, 0,  0, 0, 0, 0);

    foreach (tbl[r]) begin
      drive(tbl[r].axis, tbl[r].idle, tbl[r].inst, tbl[r].clr);
      tick();
      chk($sformatf("row%0d.blk", r), 32'(d_blk), 32'(tbl[r].blk));
      chk($sformatf("row%0d.src", r), 32'(d_src), 32'(tbl[r].src));
      chk($sformatf("row%0d.idx", r), 32'(d_idx), 32'(tbl[r].idx));
      chk($sformatf("row%0d.cyc", r), 32'(d_cyc), 32'(tbl[r].cyc));
    end

    // Parallel group: one member alone never blocks, both together do.
    pulse_reset();
    drive(7'b0000001, 7'b0, 1'b0, 1'b0);
    repeat (5) tick();
    chk("par.single.blk", 32'(p_blk), 32'd0);
    chk("par.single.cyc", 32'(p_cyc), 32'd0);
    drive(7'b1000001, 7'b0, 1'b0, 1'b0);
    repeat (3) tick();
    chk("par.arm.blk", 32'(p_blk), 32'd0);
    tick();
    chk("par.blk", 32'(p_blk), 32'd1);
    chk("par.src", 32'(p_src), 32'd2);
    chk("par.idx", 32'(p_idx), 32'd0);
    chk("par.cyc", 32'(p_cyc), 32'd4);
    chk("par.def_unaffected", 32'(d_cyc), 32'd0);

    // Sticky latch holds through release, then clear wipes it.
    pulse_reset();
    drive(7'b0000010, 7'b0, 1'b0, 1'b0);
    repeat (5) tick();
    chk("stk.blk", 32'(s_blk), 32'd1);
    chk("stk.cyc", 32'(s_cyc), 32'd5);
    drive(7'b0, 7'b0, 1'b0, 1'b0);
    tick();
    chk("def.drop.blk", 32'(d_blk), 32'd0);
    chk("def.drop.cyc", 32'(d_cyc), 32'd0);
    repeat (2) tick();
    chk("stk.hold.blk", 32'(s_blk), 32'd1);
    chk("stk.hold.cyc", 32'(s_cyc), 32'd5);
    chk("stk.hold.src", 32'(s_src), 32'd1);
    chk("stk.hold.idx", 32'(s_idx), 32'd1);
    drive(7'b0, 7'b0, 1'b0, 1'b1);
    tick();
    drive(7'b0, 7'b0, 1'b0, 1'b0);
    chk("stk.clr.blk", 32'(s_blk), 32'd0);
    chk("stk.clr.src", 32'(s_src), 32'd0);
    chk("stk.clr.idx", 32'(s_idx), 32'd0);
    chk("stk.clr.cyc", 32'(s_cyc), 32'd0);

    // Asynchronous reset mid-arming takes effect without a clock edge.
    drive(7'b0000010, 7'b0, 1'b0, 1'b0);
    repeat (2) tick();
    chk("stk.arm.cyc", 32'(s_cyc), 32'd2);
    reset_n = 1'b0;
    #1;
    chk("async.stk.cyc", 32'(s_cyc), 32'd0);
    chk("async.def.cyc", 32'(d_cyc), 32'd0);
    drive(7'b0, 7'b0, 1'b0, 1'b0);
    #1;
    reset_n = 1'b1;

    // Saturation of a narrow counter.
    tick();
    drive(7'b0000010, 7'b0, 1'b0, 1'b0);
    repeat (20) tick();
    chk("sat.cyc", 32'(c_cyc), 32'd15);
    chk("sat.blk", 32'(c_blk), 32'd1);
    chk("sat.def.cyc", 32'(d_cyc), 32'd20);

    // THRESH = 1: block one cycle after the first cond cycle.
    pulse_reset();
    chk("t1.pre.blk", 32'(t_blk), 32'd0);
    drive(7'b0000010, 7'b0, 1'b0, 1'b0);
    tick();
    chk("t1.blk", 32'(t_blk), 32'd1);
    chk("t1.src", 32'(t_src), 32'd1);
    chk("t1.cyc", 32'(t_cyc), 32'd1);
    drive(7'b0, 7'b0, 1'b0, 1'b0);
    tick();
    chk("t1.drop.blk", 32'(t_blk), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
